// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: mf select codes, field widths
// and the small match/decrement helpers used by the shadow pipeline and select logic.
package hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int TUSE_W = 2;
  localparam int TNEW_W = 2;

  localparam logic [2:0] MF_RD    = 3'd0;
  localparam logic [2:0] MF_PC4E  = 3'd1;
  localparam logic [2:0] MF_AO    = 3'd2;
  localparam logic [2:0] MF_PC4M  = 3'd3;
  localparam logic [2:0] MF_WD    = 3'd4;
  localparam logic [2:0] DEBUG_MF = 3'd7;

  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Register 0 is hardwired, so it never counts as a producer match.
  function automatic logic reg_match(input logic [REG_W-1:0] a3, input logic [REG_W-1:0] r);
    return (r != '0) && (a3 == r);
  endfunction

  // E > M > W > register file; an E producer only forwards when it is a ready link result.
  function automatic logic [2:0] fwd_sel(
    input logic [REG_W-1:0]  r,
    input logic              use_e,
    input logic [REG_W-1:0]  a3_e,
    input logic [TNEW_W-1:0] tnew_e,
    input logic              link_e,
    input logic [REG_W-1:0]  a3_m,
    input logic [TNEW_W-1:0] tnew_m,
    input logic              link_m,
    input logic [REG_W-1:0]  a3_w
  );
    logic [2:0] sel;
    sel = MF_RD;
    if (use_e && reg_match(a3_e, r) && (tnew_e == '0) && link_e)
      sel = MF_PC4E;
    else if (reg_match(a3_m, r) && (tnew_m == '0))
      sel = link_m ? MF_PC4M : MF_AO;
    else if (reg_match(a3_w, r))
      sel = MF_WD;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage_reg.sv
// One shadow-pipeline entry {rs, rt, a3, tnew, link}; clear loads a bubble, and tnew
// can be decremented (saturating at 0) or forced to 0 on load.
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              dec,
  input  logic              zero_tnew,
  input  logic [REG_W-1:0]  next_rs,
  input  logic [REG_W-1:0]  next_rt,
  input  logic [REG_W-1:0]  next_a3,
  input  logic [TNEW_W-1:0] next_tnew,
  input  logic              next_link,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  a3,
  output logic [TNEW_W-1:0] tnew,
  output logic              link
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rs   <= '0;
      rt   <= '0;
      a3   <= '0;
      tnew <= '0;
      link <= 1'b0;
    end else begin
      rs   <= next_rs;
      rt   <= next_rt;
      a3   <= next_a3;
      link <= next_link;
      if (zero_tnew)
        tnew <= '0;
      else if (dec)
        tnew <= sat_dec(next_tnew);
      else
        tnew <= next_tnew;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadow E/M/W pipeline, D-stage stall and mf select codes.
// Optional `MDU_STALL_EN adds md_D/mdu_busy so D also stalls while the multiply/divide unit is busy.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs_D,
  input  logic [REG_W-1:0]  rt_D,
  input  logic [TUSE_W-1:0] tuse_rs_D,
  input  logic [TUSE_W-1:0] tuse_rt_D,
  input  logic [REG_W-1:0]  a3_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic              link_D,
`ifdef MDU_STALL_EN
  input  logic              md_D,
  input  logic              mdu_busy,
`endif
  output logic              stall,
  output logic [2:0]        fwd_rs_D,
  output logic [2:0]        fwd_rt_D,
  output logic [2:0]        fwd_rs_E,
  output logic [2:0]        fwd_rt_E,
  output logic [2:0]        fwd_rt_M
);

  logic [REG_W-1:0]  rs_e, rt_e, a3_e;
  logic [REG_W-1:0]  rs_m, rt_m, a3_m;
  logic [REG_W-1:0]  rs_w, rt_w, a3_w;
  logic [TNEW_W-1:0] tnew_e, tnew_m, tnew_w;
  logic              link_e, link_m, link_w;
  logic              hazard_rs, hazard_rt;
  logic              unused_fields;

  hazard_stage_reg u_stage_e (
    .clk(clk), .reset(reset), .clear(stall), .dec(1'b0), .zero_tnew(1'b0),
    .next_rs(rs_D), .next_rt(rt_D), .next_a3(a3_D), .next_tnew(tnew_D), .next_link(link_D),
    .rs(rs_e), .rt(rt_e), .a3(a3_e), .tnew(tnew_e), .link(link_e)
  );

  hazard_stage_reg u_stage_m (
    .clk(clk), .reset(reset), .clear(1'b0), .dec(1'b1), .zero_tnew(1'b0),
    .next_rs(rs_e), .next_rt(rt_e), .next_a3(a3_e), .next_tnew(tnew_e), .next_link(link_e),
    .rs(rs_m), .rt(rt_m), .a3(a3_m), .tnew(tnew_m), .link(link_m)
  );

  hazard_stage_reg u_stage_w (
    .clk(clk), .reset(reset), .clear(1'b0), .dec(1'b1), .zero_tnew(1'b1),
    .next_rs(rs_m), .next_rt(rt_m), .next_a3(a3_m), .next_tnew(tnew_m), .next_link(link_m),
    .rs(rs_w), .rt(rt_w), .a3(a3_w), .tnew(tnew_w), .link(link_w)
  );

  assign unused_fields = ^{rs_m, rs_w, rt_w, tnew_w, link_w};

  // tnew_m is already decremented on entry to M, so it is the remaining delay seen from D.
  always_comb begin
    hazard_rs = (reg_match(a3_e, rs_D) && (tuse_rs_D < tnew_e)) ||
                (reg_match(a3_m, rs_D) && (tuse_rs_D < tnew_m));
    hazard_rt = (reg_match(a3_e, rt_D) && (tuse_rt_D < tnew_e)) ||
                (reg_match(a3_m, rt_D) && (tuse_rt_D < tnew_m));
    stall = hazard_rs || hazard_rt;
`ifdef MDU_STALL_EN
    if (md_D && mdu_busy)
      stall = 1'b1;
`endif
  end

  always_comb begin
    fwd_rs_D = fwd_sel(rs_D, 1'b1, a3_e, tnew_e, link_e, a3_m, tnew_m, link_m, a3_w);
    fwd_rt_D = fwd_sel(rt_D, 1'b1, a3_e, tnew_e, link_e, a3_m, tnew_m, link_m, a3_w);
    fwd_rs_E = fwd_sel(rs_e, 1'b0, a3_e, tnew_e, link_e, a3_m, tnew_m, link_m, a3_w);
    fwd_rt_E = fwd_sel(rt_e, 1'b0, a3_e, tnew_e, link_e, a3_m, tnew_m, link_m, a3_w);
    fwd_rt_M = reg_match(a3_w, rt_m) ? MF_WD : MF_RD;
  end

endmodule
